// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Locks onto a serial stream from a 4-bit LFSR generator
//   (s <= {s[2:0], s[0]^s[2]}) and counts bit errors once locked.
//   The checker first seeds its local LFSR from four received bits. It then
//   verifies LOCK_THRESH predicted bits before declaring lock. While locked,
//   it flywheels on its own prediction.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   rx_valid     qualifies rx_bit
//   rx_bit       received serial bit
//   clear_count  synchronous clear of err_count (wins over an increment)
//   lock         high while in LOCKED
//   err_pulse    one-cycle flag for a mismatch checked in LOCKED
//   err_count    saturating mismatch count (LOCKED only)
//   recovered    local LFSR state, newest bit in bit 0
module lfsr_checker #(
  parameter int LOCK_THRESH = 8,
  parameter int LOSS_THRESH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic       rx_bit,
  input  logic       clear_count,
  output logic       lock,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [3:0] recovered
);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t     state, state_nx;
  logic [3:0] lfsr;
  logic [1:0] seed_cnt;
  logic [3:0] match_cnt;
  logic [3:0] miss_cnt;

  logic       expected;
  logic       mismatch;
  logic [3:0] seeded;

  assign expected = lfsr[0] ^ lfsr[2];
  assign mismatch = rx_bit ^ expected;
  assign seeded   = {lfsr[2:0], rx_bit};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (rx_valid) begin
      case (state)
        SEED:
          // An all-zero seed would lock the generator model at zero; reseed.
          if (seed_cnt == 2'd3 && seeded != 4'b0000) state_nx = VERIFY;
        VERIFY:
          if (mismatch)                                state_nx = SEED;
          else if (match_cnt == 4'(LOCK_THRESH - 1))   state_nx = LOCKED;
        LOCKED:
          if (mismatch && miss_cnt == 4'(LOSS_THRESH - 1)) state_nx = SEED;
        default: state_nx = SEED;
      endcase
    end
  end

  // Datapath: local LFSR, counters and error reporting
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= 4'b0000;
      seed_cnt  <= 2'd0;
      match_cnt <= 4'd0;
      miss_cnt  <= 4'd0;
      err_pulse <= 1'b0;
      err_count <= 8'd0;
    end else begin
      err_pulse <= 1'b0;
      if (rx_valid) begin
        case (state)
          SEED: begin
            lfsr      <= seeded;
            // 2-bit counter wraps to 0 after the 4th bit, which covers both
            // the zero-seed retry and the move to VERIFY.
            seed_cnt  <= seed_cnt + 2'd1;
            match_cnt <= 4'd0;
          end
          VERIFY: begin
            if (mismatch) begin
              // Bit is discarded; local state kept for the reseed.
              seed_cnt <= 2'd0;
            end else begin
              lfsr      <= {lfsr[2:0], expected};
              match_cnt <= match_cnt + 4'd1;
              miss_cnt  <= 4'd0;
            end
          end
          LOCKED: begin
            // Flywheel: always advance on the prediction, never the rx bit.
            lfsr <= {lfsr[2:0], expected};
            if (mismatch) begin
              err_pulse <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              if (state_nx == SEED) begin
                miss_cnt <= 4'd0;
                seed_cnt <= 2'd0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end else begin
              miss_cnt <= 4'd0;
            end
          end
          default: ;
        endcase
      end
      if (clear_count) err_count <= 8'd0;
    end
  end

  // Outputs (all driven straight from flops)
  always_comb begin
    lock      = (state == LOCKED);
    recovered = lfsr;
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: a behavioural checker model feeds a scoreboard queue
// on every driven cycle, a monitor pops and compares after each edge, and the
// scenario tasks add fixed-value checks at the milestones of each scenario.
module tb_lfsr_checker;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic       rx_bit = 1'b0;
  logic       clear_count = 1'b0;
  logic       lock, err_pulse;
  logic [7:0] err_count;
  logic [3:0] recovered;

  lfsr_checker #(.LOCK_THRESH(8), .LOSS_THRESH(3)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_bit(rx_bit),
    .clear_count(clear_count), .lock(lock), .err_pulse(err_pulse),
    .err_count(err_count), .recovered(recovered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lock;
    logic       pulse;
    logic [7:0] cnt;
    logic [3:0] rec;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  // Reference model state: 0 = seeding, 1 = verifying, 2 = locked
  int       m_mode, m_seed, m_match, m_miss, m_cnt;
  bit [3:0] m_reg;
  bit       m_pulse;
  logic [3:0] gen;

  function automatic bit gen_next();
    bit b;
    b = gen[0] ^ gen[2];
    gen = {gen[2:0], b};
    return b;
  endfunction

  task automatic model_step(input bit rst, input bit v, input bit b, input bit clr);
    bit p;
    if (rst) begin
      m_mode = 0; m_seed = 0; m_match = 0; m_miss = 0; m_cnt = 0;
      m_reg = 4'b0000; m_pulse = 1'b0;
      return;
    end
    m_pulse = 1'b0;
    if (v) begin
      p = m_reg[0] ^ m_reg[2];
      if (m_mode == 0) begin
        m_reg = {m_reg[2:0], b};
        m_seed++;
        if (m_seed == 4) begin
          m_seed = 0;
          if (m_reg != 4'b0000) begin m_mode = 1; m_match = 0; end
        end
      end else if (m_mode == 1) begin
        if (b != p) begin
          m_mode = 0; m_seed = 0;
        end else begin
          m_reg = {m_reg[2:0], p};
          m_match++;
          if (m_match == 8) begin m_mode = 2; m_miss = 0; end
        end
      end else begin
        m_reg = {m_reg[2:0], p};
        if (b != p) begin
          m_pulse = 1'b1;
          if (m_cnt < 255) m_cnt++;
          m_miss++;
          if (m_miss == 3) begin m_mode = 0; m_seed = 0; m_miss = 0; end
        end else begin
          m_miss = 0;
        end
      end
    end
    if (clr) m_cnt = 0;
  endtask

  // Drive one cycle, record the model's expectation, and return once the
  // monitor has compared it.
  task automatic send(input bit rst, input bit v, input bit b, input bit clr);
    exp_t e;
    @(negedge clk);
    reset = rst; rx_valid = v; rx_bit = b; clear_count = clr;
    model_step(rst, v, b, clr);
    e.lock = (m_mode == 2); e.pulse = m_pulse; e.cnt = 8'(m_cnt); e.rec = m_reg;
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    exp_t a;
    #1;
    if (sb.size() > 0) begin
      a = sb.pop_front();
      total++;
      if ({lock, err_pulse, err_count, recovered} !== {a.lock, a.pulse, a.cnt, a.rec})
        $display("FAIL sb_cycle t=%0t got lock=%b pulse=%b cnt=%0d rec=%b exp lock=%b pulse=%b cnt=%0d rec=%b",
                 $time, lock, err_pulse, err_count, recovered, a.lock, a.pulse, a.cnt, a.rec);
      else passed++;
    end
  end

  task automatic test_reset();
    send(1, 1, 1, 0);
    total++;
    if ({lock, err_pulse, err_count, recovered} !== 14'd0)
      $display("FAIL reset_outputs got %b exp 0", {lock, err_pulse, err_count, recovered});
    else passed++;
  endtask

  task automatic test_lock_basic();
    gen = 4'b1001;
    for (int i = 1; i <= 12; i++) begin
      send(0, 1, gen_next(), 0);
      if (i == 4) begin
        total++;
        if (recovered !== 4'b1101) $display("FAIL basic_recovered got %b exp 1101", recovered);
        else passed++;
      end
      if (i == 11 || i == 12) begin
        total++;
        if (lock !== (i == 12)) $display("FAIL basic_lock bit%0d got %b exp %b", i, lock, i == 12);
        else passed++;
      end
    end
    total++;
    if (err_count !== 8'd0) $display("FAIL basic_errcnt got %0d exp 0", err_count);
    else passed++;
  endtask

  task automatic test_single_error();
    send(0, 1, ~gen_next(), 0);
    total++;
    if ({lock, err_pulse, err_count} !== {1'b1, 1'b1, 8'd1})
      $display("FAIL single_err got lock=%b pulse=%b cnt=%0d exp 1 1 1", lock, err_pulse, err_count);
    else passed++;
    for (int i = 0; i < 6; i++) send(0, 1, gen_next(), 0);
    total++;
    if ({lock, err_pulse, err_count} !== {1'b1, 1'b0, 8'd1})
      $display("FAIL single_after got lock=%b pulse=%b cnt=%0d exp 1 0 1", lock, err_pulse, err_count);
    else passed++;
  endtask

  task automatic test_loss();
    send(0, 1, gen_next(), 1);
    for (int i = 1; i <= 3; i++) begin
      send(0, 1, ~gen_next(), 0);
      total++;
      if (lock !== (i < 3)) $display("FAIL loss_lock miss%0d got %b exp %b", i, lock, i < 3);
      else passed++;
    end
    total++;
    if (err_count !== 8'd3) $display("FAIL loss_errcnt got %0d exp 3", err_count);
    else passed++;
    for (int i = 1; i <= 12; i++) send(0, 1, gen_next(), 0);
    total++;
    if (lock !== 1'b1) $display("FAIL loss_relock got %b exp 1", lock);
    else passed++;
  endtask

  task automatic test_zero_seed();
    send(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) send(0, 1, 0, 0);
    total++;
    if ({lock, recovered} !== 5'd0) $display("FAIL zero_seed got lock=%b rec=%b exp 0 0000", lock, recovered);
    else passed++;
    test_lock_basic();
  endtask

  task automatic test_verify_error();
    send(1, 0, 0, 0);
    gen = 4'b1001;
    for (int i = 1; i <= 6; i++) send(0, 1, gen_next(), 0);
    send(0, 1, ~gen_next(), 0);
    total++;
    if ({lock, err_pulse, err_count} !== 10'd0)
      $display("FAIL verify_err got lock=%b pulse=%b cnt=%0d exp 0 0 0", lock, err_pulse, err_count);
    else passed++;
    for (int i = 1; i <= 12; i++) begin
      send(0, 1, gen_next(), 0);
      if (i >= 11) begin
        total++;
        if (lock !== (i == 12)) $display("FAIL verify_relock bit%0d got %b exp %b", i, lock, i == 12);
        else passed++;
      end
    end
  endtask

  task automatic test_gaps();
    send(1, 0, 0, 0);
    gen = 4'b1001;
    for (int i = 1; i <= 12; i++) begin
      int g;
      g = int'($urandom_range(0, 3));
      for (int k = 0; k < g; k++) send(0, 0, 1'($urandom), 0);
      send(0, 1, gen_next(), 0);
      if (i == 4) begin
        total++;
        if (recovered !== 4'b1101) $display("FAIL gaps_recovered got %b exp 1101", recovered);
        else passed++;
      end
      if (i >= 11) begin
        total++;
        if (lock !== (i == 12)) $display("FAIL gaps_lock bit%0d got %b exp %b", i, lock, i == 12);
        else passed++;
      end
    end
  endtask

  task automatic test_saturation();
    // Two misses then a hit never reaches the loss threshold.
    for (int i = 0; i < 150; i++) begin
      send(0, 1, ~gen_next(), 0);
      send(0, 1, ~gen_next(), 0);
      send(0, 1, gen_next(), 0);
    end
    total++;
    if ({lock, err_count} !== {1'b1, 8'hFF}) $display("FAIL sat_count got lock=%b cnt=%0d exp 1 255", lock, err_count);
    else passed++;
    send(0, 1, ~gen_next(), 1);
    total++;
    if ({err_pulse, err_count} !== {1'b1, 8'd0}) $display("FAIL sat_clear got pulse=%b cnt=%0d exp 1 0", err_pulse, err_count);
    else passed++;
  endtask

  task automatic test_reset_locked();
    send(0, 1, gen_next(), 0);
    total++;
    if (lock !== 1'b1) $display("FAIL rstlock_pre got %b exp 1", lock);
    else passed++;
    send(1, 1, 1, 1);
    total++;
    if ({lock, err_pulse, err_count, recovered} !== 14'd0)
      $display("FAIL rstlock_outputs got %b exp 0", {lock, err_pulse, err_count, recovered});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_single_error();
    test_loss();
    test_zero_seed();
    test_verify_error();
    test_gaps();
    test_saturation();
    test_reset_locked();
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 8, is the number of consecutive correct bits in VERIFY needed to enter LOCKED (range 1..15).
REQ-002 Parameter LOSS_THRESH, default 3, is the number of consecutive mismatches in LOCKED that drops lock (range 1..15).
REQ-003 clk  input  1  clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  qualifies rx_bit; the checker ignores rx_bit on cycles with rx_valid low.
REQ-006 rx_bit  input  1  serial bit received from the 4-bit LFSR generator, one new feedback bit per valid cycle.
REQ-007 clear_count  input  1  synchronous clear of err_count.
REQ-008 lock  output  1  high while in state LOCKED.
REQ-009 err_pulse  output  1  one-cycle flag for a mismatching bit checked in LOCKED.
REQ-010 err_count  output  8  saturating count of mismatches detected in LOCKED.
REQ-011 recovered  output  4  current local LFSR state, equal to the last 4 accepted or predicted bits with the newest bit in bit 0.

Function
REQ-012 Generator model: state s advances to {s[2:0], s[0]^s[2]}, and each advance emits the new bit s[0]^s[2].
REQ-013 The checker has three states: SEED, VERIFY and LOCKED. All outputs are registered.
REQ-014 SEED, valid bit: local <= {local[2:0], rx_bit}; seed_cnt increments from 0 to 3.
REQ-015 SEED, 4th valid bit: if the shifted-in value is nonzero, go to VERIFY with match_cnt=0. If it is 4'b0000, stay in SEED with seed_cnt=0, because the zero state is degenerate.
REQ-016 VERIFY/LOCKED, valid bit: expected = local[0]^local[2]; local <= {local[2:0], expected}. The predicted bit is always used, so the checker flywheels through errors.
REQ-017 VERIFY, match: match_cnt increments; when it reaches LOCK_THRESH, go to LOCKED.
REQ-018 VERIFY, mismatch: go to SEED, discard the bit, seed_cnt=0, local unchanged. err_count is not affected.
REQ-019 LOCKED, mismatch: err_pulse=1 on the next cycle, err_count increments, miss_cnt increments.
REQ-020 LOCKED, match: miss_cnt=0.
REQ-021 LOCKED: when miss_cnt reaches LOSS_THRESH, go to SEED with seed_cnt=0. The mismatch that triggers this is still counted and still pulses err_pulse.
REQ-022 lock rises on the clock edge that accepts the LOCK_THRESH-th matching bit (visible the next cycle), and falls on the edge that accepts the LOSS_THRESH-th consecutive mismatch.
REQ-023 err_count saturates at 8'hFF; a further mismatch pulses err_pulse but does not change the count.
REQ-024 clear_count sets err_count to 0. If clear_count and a mismatch occur in the same cycle, clear wins and err_count = 0.
REQ-025 rx_valid low: no state, counter or local change; err_pulse = 0.
REQ-026 err_pulse is never high for two cycles from a single bit, and is never high outside LOCKED-checked bits.

Reset
REQ-027 reset sets: state=SEED, local=4'b0000, seed_cnt=0, match_cnt=0, miss_cnt=0, lock=0, err_pulse=0, err_count=0, recovered=4'b0000.
REQ-028 reset takes priority over rx_valid and clear_count. Reset mid-lock discards all sync state, and rx_bit in the reset cycle is ignored.

Verification
REQ-029 Generator seed 4'b1001 yields the period-7 stream 1,1,0,1,0,0,1,... Feed it with rx_valid=1 continuously -> recovered=4'b1101 after bit 4; lock=1 the cycle after bit 12; err_count stays 0.
REQ-030 While locked, invert one bit -> err_pulse=1 for exactly one cycle, err_count=1, lock stays 1; subsequent correct bits match again through flywheel prediction.
REQ-031 While locked, invert 3 consecutive bits -> err_count=3, lock=0 the cycle after the 3rd bit; re-seeding then relocks after 12 further clean bits.
REQ-032 Feed 4 zero bits -> remains in SEED with lock=0. Then apply the REQ-029 stream -> locks normally.
REQ-033 Invert bit 7 during VERIFY -> returns to SEED, err_count=0; relocks 12 clean bits later. Also: insert rx_valid=0 gaps of random length -> identical results to the gapless run.
REQ-034 Force 300 errors while locked -> err_count=8'hFF. Assert clear_count in the same cycle as a mismatch -> err_count=0. Assert reset while locked -> all outputs 0 the next cycle.
